// File: rtl/decoder_pipe.sv
// ---------------------------------------------------------------------------
// decoder_pipe
//   Registered binary-to-one-hot decoder with a valid/ready handshake and a
//   two-entry skid buffer (main + skid). Sustains one index per cycle. The
//   decode is done on the input side, so out_* come straight off a register.
//   Typical use: regfile write-enable generation or CSR/line select between
//   pipeline stages.
//
// Parameters
//   IN_W   index width, legal range 1..8 (default 5)
//   OUT_W  one-hot width, fixed at 1 << IN_W (not overridable)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   in_valid    upstream holds a valid index
//   in_ready    block can accept this cycle (registered, = !skid_v)
//   in_idx      binary index to decode
//   in_en       qualifier, 0 yields an all-zero one-hot (still a transfer)
//   out_valid   out_onehot/out_idx hold a valid result
//   out_ready   downstream accepts this cycle
//   out_onehot  decoded vector
//   out_idx     index carried alongside the decode
//
// Build option
//   DECODER_PIPE_ZERO_MASK_EN  when defined, index 0 decodes to all-zero
//                              (x0-style non-writable register). out_idx
//                              still carries 0; handshake is unchanged.
// ---------------------------------------------------------------------------
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_EMPTY  | main and skid both empty, in_ready=1
//   ST_BUSY   | main holds the presented result, skid empty, in_ready=1
//   ST_FULL   | main presented, skid holds the next result, in_ready=0
// ---------------------------------------------------------------------------
module decoder_pipe #(
  parameter  int IN_W  = 5,
  localparam int OUT_W = 1 << IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_idx,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic [IN_W-1:0]  out_idx
);

  // Encoding is {main_v, skid_v}; (0,1) is never produced.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b10,
    ST_FULL  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [OUT_W-1:0] main_oh_q, main_oh_d;
  logic [IN_W-1:0]  main_idx_q, main_idx_d;
  logic [OUT_W-1:0] skid_oh_q, skid_oh_d;
  logic [IN_W-1:0]  skid_idx_q, skid_idx_d;

  logic             accept;
  logic             xfer;
  logic [OUT_W-1:0] dec_oh;

  // ---------------------------------------------------------------------
  // Input-side decode
  // ---------------------------------------------------------------------
  always_comb begin
    dec_oh = '0;
`ifdef DECODER_PIPE_ZERO_MASK_EN
    if (in_en && (in_idx != '0)) begin
      dec_oh[in_idx] = 1'b1;
    end
`else
    if (in_en) begin
      dec_oh[in_idx] = 1'b1;
    end
`endif
  end

  // in_ready comes from a flop, so there is no path from out_ready to it.
  assign accept = in_valid && in_ready_q;
  assign xfer   = (state_q != ST_EMPTY) && out_ready;

  // ---------------------------------------------------------------------
  // Next-state and datapath load control
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    main_oh_d  = main_oh_q;
    main_idx_d = main_idx_q;
    skid_oh_d  = skid_oh_q;
    skid_idx_d = skid_idx_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d    = ST_BUSY;
          main_oh_d  = dec_oh;
          main_idx_d = in_idx;
        end
      end

      ST_BUSY: begin
        if (accept && xfer) begin
          // Replace main in the same cycle: no bubble.
          main_oh_d  = dec_oh;
          main_idx_d = in_idx;
        end else if (accept) begin
          state_d    = ST_FULL;
          skid_oh_d  = dec_oh;
          skid_idx_d = in_idx;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end

      ST_FULL: begin
        if (xfer) begin
          state_d    = ST_BUSY;
          main_oh_d  = skid_oh_q;
          main_idx_d = skid_idx_q;
        end
      end

      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    in_ready_d = (state_d != ST_FULL);
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_oh_q  <= '0;
      main_idx_q <= '0;
      skid_oh_q  <= '0;
      skid_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_oh_q  <= main_oh_d;
      main_idx_q <= main_idx_d;
      skid_oh_q  <= skid_oh_d;
      skid_idx_q <= skid_idx_d;
    end
  end

  // Outputs come straight from the main register.
  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != ST_EMPTY);
  assign out_onehot = main_oh_q;
  assign out_idx    = main_idx_q;

endmodule

// File: tb/tb_decoder_pipe.sv
// ---------------------------------------------------------------------------
// tb_decoder_pipe
//   Scoreboard bench for decoder_pipe. Accepted inputs push their expected
//   {onehot, idx} into a queue; a monitor on the falling edge pops and
//   compares on every output transfer, and checks that a stalled output
//   holds still. Directed phases cover reset, latency, streaming,
//   backpressure, enable/zero-index, reset while full; a random phase ends it.
// ---------------------------------------------------------------------------
module tb_decoder_pipe;
  localparam int IN_W  = 5;
  localparam int OUT_W = 1 << IN_W;

  typedef logic [255:0] w_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_idx;
  logic             in_en;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_onehot;
  logic [IN_W-1:0]  out_idx;

  decoder_pipe #(.IN_W(IN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_en     (in_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_onehot(out_onehot),
    .out_idx   (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [OUT_W-1:0] oh;
    logic [IN_W-1:0]  idx;
  } exp_t;

  exp_t sb[$];

  // Reference: bit i is set iff enabled and i equals the index.
  function automatic logic [OUT_W-1:0] exp_onehot(input logic [IN_W-1:0] idx,
                                                  input logic en);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (en && (i == int'(idx))) v[i] = 1'b1;
    end
`ifdef DECODER_PIPE_ZERO_MASK_EN
    if (idx == '0) v = '0;
`endif
    return v;
  endfunction

  task automatic chk(input string name, input w_t act, input w_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one index and hold it until accepted (bounded).
  task automatic send(input int idx, input logic en);
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_idx   = IN_W'(idx);
    in_en    = en;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready && !rst) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("send_accepted", w_t'(done), w_t'(1));
  endtask

  // ---------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------
  logic             hold_prev = 1'b0;
  logic [OUT_W-1:0] prev_oh;
  logic [IN_W-1:0]  prev_idx;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("stall_valid", w_t'(out_valid), w_t'(1));
        chk("stall_onehot", w_t'(out_onehot), w_t'(prev_oh));
        chk("stall_idx", w_t'(out_idx), w_t'(prev_idx));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got idx %0d expected no output", out_idx);
        end else begin
          e = sb.pop_front();
          chk("sb_onehot", w_t'(out_onehot), w_t'(e.oh));
          chk("sb_idx", w_t'(out_idx), w_t'(e.idx));
        end
      end
      if (in_valid && in_ready) begin
        e.oh  = exp_onehot(in_idx, in_en);
        e.idx = in_idx;
        sb.push_back(e);
      end
      hold_prev = out_valid && !out_ready;
      prev_oh   = out_onehot;
      prev_idx  = out_idx;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    logic acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_idx    = '0;
    in_en     = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", w_t'(out_valid), w_t'(0));
    chk("rst_onehot", w_t'(out_onehot), w_t'(0));
    chk("rst_idx", w_t'(out_idx), w_t'(0));
    chk("rst_in_ready", w_t'(in_ready), w_t'(1));
    tick();
    rst = 1'b0;

    // Single index, one-cycle latency, then a bubble
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_idx    = IN_W'(7);
    in_en     = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_valid", w_t'(out_valid), w_t'(1));
    chk("lat_onehot", w_t'(out_onehot), w_t'(exp_onehot(IN_W'(7), 1'b1)));
    chk("lat_idx", w_t'(out_idx), w_t'(7));
    tick();
    @(negedge clk);
    chk("lat_bubble", w_t'(out_valid), w_t'(0));
    tick();

    // Back-to-back stream of every index
    for (int i = 0; i <= OUT_W; i++) begin
      if (i < OUT_W) begin
        in_valid = 1'b1;
        in_idx   = IN_W'(i);
        in_en    = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < OUT_W) chk("stream_in_ready", w_t'(in_ready), w_t'(1));
      if (i > 0) chk("stream_gap", w_t'(out_valid), w_t'(1));
      tick();
    end
    @(negedge clk);
    chk("stream_end", w_t'(out_valid), w_t'(0));
    tick();

    // Backpressure: 1,2,3,4 with out_ready dropped after the first output
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_en     = 1'b1;
    in_idx    = IN_W'(1);
    tick();
    in_idx = IN_W'(2);
    tick();
    in_idx    = IN_W'(3);
    out_ready = 1'b0;
    tick();
    in_idx = IN_W'(4);
    @(negedge clk);
    chk("bp_in_ready_low", w_t'(in_ready), w_t'(0));
    chk("bp_main_idx", w_t'(out_idx), w_t'(2));
    tick();
    @(negedge clk);
    chk("bp_hold_ready", w_t'(in_ready), w_t'(0));
    chk("bp_hold_idx", w_t'(out_idx), w_t'(2));
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_release_ready", w_t'(in_ready), w_t'(1));
    chk("bp_release_idx", w_t'(out_idx), w_t'(3));
    tick();
    in_valid = 1'b0;
    repeat (3) tick();

    // Enable low still transfers with an all-zero vector
    send(9, 1'b0);
    @(negedge clk);
    chk("en0_valid", w_t'(out_valid), w_t'(1));
    chk("en0_onehot", w_t'(out_onehot), w_t'(0));
    chk("en0_idx", w_t'(out_idx), w_t'(9));
    tick();
    send(0, 1'b1);
    send(OUT_W - 1, 1'b1);
    send(1, 1'b1);
    repeat (3) tick();

    // Fill to FULL, then reset: both entries dropped
    out_ready = 1'b0;
    send(5, 1'b1);
    send(6, 1'b1);
    in_valid = 1'b1;
    in_idx   = IN_W'(20);
    in_en    = 1'b1;
    @(negedge clk);
    chk("full_in_ready", w_t'(in_ready), w_t'(0));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", w_t'(out_valid), w_t'(0));
    chk("flush_in_ready", w_t'(in_ready), w_t'(1));
    chk("flush_onehot", w_t'(out_onehot), w_t'(0));
    chk("flush_idx", w_t'(out_idx), w_t'(0));
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_next_valid", w_t'(out_valid), w_t'(1));
    chk("flush_next_idx", w_t'(out_idx), w_t'(20));
    tick();
    @(negedge clk);
    chk("flush_alone", w_t'(out_valid), w_t'(0));
    tick();

    // Random traffic and random backpressure
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      out_ready = ($urandom_range(0, 2) != 0);
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_idx   = IN_W'($urandom);
        in_en    = ($urandom_range(0, 4) != 0);
      end
    end

    // Drain
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
    chk("drain_empty", w_t'(sb.size()), w_t'(0));
    tick();
    @(negedge clk);
    chk("drain_out_valid", w_t'(out_valid), w_t'(0));
    chk("drain_in_ready", w_t'(in_ready), w_t'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
